bm_gauss_output: RTL and testbench

//  Final Box-Muller stage: consumes f = sqrt(-2ln(u0)) from the log/sqrt path and the

---
 rtl/bm_gauss_output.sv | 238 +++++++++++++++++++++++
 tb/tb_bm_gauss_output.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bm_gauss_output.sv
// bm_gauss_output: final Box-Muller stage. Forms x0 = f*g0 and x1 = f*g1,
// rounds half-up and saturates them to Q4.12, buffers the pairs in a FIFO
// and serializes them as x0 then x1 on one valid/ready stream.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   in_valid/in_ready input handshake for one (f, g0, g1) triple
//   f                 unsigned Q4.13 magnitude term
//   g0, g1            signed Q1.15 cos/sin terms
//   out_valid/ready   output handshake
//   out_data          signed Q4.12 sample, 0 when no data is held
//   out_sel           0 = x0, 1 = x1 of the head pair
//   sat_count         clamped-sample counter (BM_OUT_SATCNT_EN), else 0
//
// Build option: define BM_OUT_SATCNT_EN to enable the saturation counter.
module bm_gauss_output #(
    parameter int F_W   = 17,
    parameter int G_W   = 16,
    parameter int X_W   = 16,
    parameter int SHIFT = 16,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [F_W-1:0] f,
    input  logic [G_W-1:0] g0,
    input  logic [G_W-1:0] g1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] out_data,
    output logic           out_sel,
    output logic [15:0]    sat_count
);

    localparam int P_W = F_W + 1 + G_W;
    localparam int A_W = $clog2(DEPTH);
    localparam int C_W = A_W + 1;

    localparam logic signed [P_W-1:0] HALF  = P_W'(1) << (SHIFT - 1);
    localparam logic signed [P_W-1:0] X_MAX = P_W'((1 << (X_W - 1)) - 1);
    localparam logic signed [P_W-1:0] X_MIN = -X_MAX - P_W'(1);
    localparam logic [C_W:0]          DEPTH_C = (C_W + 1)'(DEPTH);

    typedef enum logic {
        SEL_X0 = 1'b0,
        SEL_X1 = 1'b1
    } sel_e;

    // Round half-up, arithmetic shift, clamp. MSB of the result flags a clamp.
    function automatic logic [X_W:0] rnd_sat(input logic signed [P_W-1:0] p);
        logic signed [P_W-1:0] r;
        r = (p + HALF) >>> SHIFT;
        if (r > X_MAX) begin
            return {1'b1, X_MAX[X_W-1:0]};
        end
        if (r < X_MIN) begin
            return {1'b1, X_MIN[X_W-1:0]};
        end
        return {1'b0, r[X_W-1:0]};
    endfunction

    // Pipe stage S1: operand registers
    logic           s1_v_q;
    logic [F_W-1:0] s1_f_q;
    logic [G_W-1:0] s1_g0_q;
    logic [G_W-1:0] s1_g1_q;

    // Pipe stage S2: full-precision products
    logic                  s2_v_q;
    logic signed [P_W-1:0] s2_p0_q;
    logic signed [P_W-1:0] s2_p1_q;
    logic signed [P_W-1:0] p0_d;
    logic signed [P_W-1:0] p1_d;
    logic signed [P_W-1:0] f_ext;
    logic signed [P_W-1:0] g0_ext;
    logic signed [P_W-1:0] g1_ext;

    // FIFO of (x1, x0) pairs
    logic [2*X_W-1:0] mem_q [DEPTH];
    logic [A_W-1:0]   wr_ptr_q;
    logic [A_W-1:0]   rd_ptr_q;
    logic [C_W-1:0]   cnt_q;
    logic [2*X_W-1:0] head;

    logic [X_W:0]   r0;
    logic [X_W:0]   r1;
    logic           accept;
    logic           push;
    logic           pop;
    logic [C_W:0]   busy;

    sel_e sel_q;
    sel_e sel_d;

    // Credit covers both pipe stages, so anything accepted always has a slot.
    assign busy = {1'b0, cnt_q}
                + (C_W + 1)'(s1_v_q)
                + (C_W + 1)'(s2_v_q);
    assign in_ready = reset && (busy < DEPTH_C);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q <= 1'b0;
        end else begin
            s1_v_q <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_f_q  <= f;
            s1_g0_q <= g0;
            s1_g1_q <= g1;
        end
    end

    // Zero-extend f to make it a positive signed operand.
    assign f_ext  = P_W'({1'b0, s1_f_q});
    assign g0_ext = P_W'($signed(s1_g0_q));
    assign g1_ext = P_W'($signed(s1_g1_q));
    assign p0_d   = f_ext * g0_ext;
    assign p1_d   = f_ext * g1_ext;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_v_q <= 1'b0;
        end else begin
            s2_v_q <= s1_v_q;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_v_q) begin
            s2_p0_q <= p0_d;
            s2_p1_q <= p1_d;
        end
    end

    assign r0   = rnd_sat(s2_p0_q);
    assign r1   = rnd_sat(s2_p1_q);
    assign push = s2_v_q;
    assign pop  = out_valid && out_ready && (sel_q == SEL_X1);
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {r1[X_W-1:0], r0[X_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + A_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + A_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + C_W'(1);
                2'b01:   cnt_q <= cnt_q - C_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign out_valid = (cnt_q != '0);

    // Output serializer FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q <= SEL_X0;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        sel_d    = sel_q;
        out_data = '0;
        out_sel  = 1'b0;
        if (out_valid) begin
            case (sel_q)
                SEL_X0: begin
                    out_data = head[X_W-1:0];
                    out_sel  = 1'b0;
                    if (out_ready) begin
                        sel_d = SEL_X1;
                    end
                end
                SEL_X1: begin
                    out_data = head[2*X_W-1:X_W];
                    out_sel  = 1'b1;
                    if (out_ready) begin
                        sel_d = SEL_X0;
                    end
                end
                default: sel_d = SEL_X0;
            endcase
        end
    end

`ifdef BM_OUT_SATCNT_EN
    logic [15:0] sat_q;
    logic [15:0] sat_d;
    logic [1:0]  nsat;
    logic [16:0] sat_sum;

    // Sticky at all-ones instead of wrapping.
    always_comb begin
        nsat    = push ? ({1'b0, r0[X_W]} + {1'b0, r1[X_W]}) : 2'd0;
        sat_sum = {1'b0, sat_q} + 17'(nsat);
        sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_count = sat_q;
`else
    logic sat_unused;
    assign sat_unused = r0[X_W] ^ r1[X_W];
    assign sat_count  = '0;
`endif

endmodule

// File: tb/tb_bm_gauss_output.sv
// Bench for bm_gauss_output: queue-based reference model with a per-cycle
// compare process plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_bm_gauss_output;

    localparam int DEPTH = 4;

`ifdef BM_OUT_SATCNT_EN
    localparam bit SATCNT = 1'b1;
`else
    localparam bit SATCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] f = '0;
    logic [15:0] g0 = '0;
    logic [15:0] g1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sel;
    logic [15:0] sat_count;

    bm_gauss_output #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .g0        (g0),
        .g1        (g1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        sel;
        int          rdy;
    } smp_t;

    smp_t        expq[$];
    int          pend_rdy[$];
    int          pend_n[$];
    logic [15:0] obs[$];
    int cyc = 0;
    int outstanding = 0;
    int sat_exp = 0;
    int accepts = 0;
    int checks = 0;
    int errors = 0;
    logic m_ir = 1'b0;
    logic m_ov = 1'b0;
    logic rdy_set = 1'b0;
    logic toggle = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // x = round_half_up(f * g / 2^16), clamped to int16
    function automatic logic [15:0] model_x(input logic [16:0] fv,
                                            input logic [15:0] gv,
                                            output int clip);
        longint p;
        longint r;
        p = longint'(fv) * longint'($signed(gv));
        r = (p + 64'sd32768) >>> 16;
        clip = 1;
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        clip = 0;
        return 16'(r);
    endfunction

    // Reference model: advances on each rising edge.
    initial begin
        logic [15:0] v0;
        logic [15:0] v1;
        int c0;
        int c1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                expq.delete();
                pend_rdy.delete();
                pend_n.delete();
                outstanding = 0;
                sat_exp = 0;
            end else begin
                if (m_ov && out_ready) begin
                    if (expq[0].sel) outstanding--;
                    void'(expq.pop_front());
                end
                if (in_valid && m_ir) begin
                    v0 = model_x(f, g0, c0);
                    v1 = model_x(f, g1, c1);
                    expq.push_back('{val: v0, sel: 1'b0, rdy: cyc + 2});
                    expq.push_back('{val: v1, sel: 1'b1, rdy: cyc + 2});
                    outstanding++;
                    accepts++;
                    if (SATCNT) begin
                        pend_rdy.push_back(cyc + 2);
                        pend_n.push_back(c0 + c1);
                    end
                end
                while (pend_rdy.size() > 0 && pend_rdy[0] <= cyc) begin
                    sat_exp = sat_exp + pend_n[0];
                    if (sat_exp > 65535) sat_exp = 65535;
                    void'(pend_rdy.pop_front());
                    void'(pend_n.pop_front());
                end
            end
        end
    end

    // Compare process: every falling edge.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_sel;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_sel = 1'b0;
        forever begin
            @(negedge clk);
            m_ir = reset && (outstanding < DEPTH);
            m_ov = (expq.size() > 0) && (expq[0].rdy <= cyc);
            if (cyc > 0) begin
                chk("in_ready", in_ready, m_ir);
                chk("out_valid", out_valid, m_ov);
                if (m_ov) begin
                    chk("out_data", out_data, expq[0].val);
                    chk("out_sel", out_sel, expq[0].sel);
                end else begin
                    chk("idle_data", out_data, 0);
                    chk("idle_sel", out_sel, 0);
                end
                chk("sat_count", sat_count, sat_exp);
                if (prev_stall && out_valid) begin
                    chk("hold_data", out_data, prev_data);
                    chk("hold_sel", out_sel, prev_sel);
                end
                if (m_ov && out_ready && reset) obs.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready && reset;
            prev_data = out_data;
            prev_sel = out_sel;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle ? ~out_ready : rdy_set;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [16:0] fv, input logic [15:0] a,
                        input logic [15:0] b);
        bit done;
        done = 1'b0;
        f = fv;
        g0 = a;
        g1 = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed %0b", in_ready);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            tick(1);
            done = (expq.size() == 0) && (outstanding == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d samples left", expq.size());
        end
    endtask

    task automatic chk_obs(input string name, input int idx, input logic [15:0] exp);
        if (idx < obs.size()) begin
            chk(name, obs[idx], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: sample %0d missing, expected %0h", name, idx, exp);
        end
    endtask

    initial begin
        int n0;
        int a0;
        tick(3);
        reset = 1'b1;
        rdy_set = 1'b1;
        tick(2);

        // 1: unity f, +/-0.5 -> 0x0800 / 0xF800, visible 3 cycles after accept
        n0 = obs.size();
        send(17'h02000, 16'h4000, 16'hC000);
        @(negedge clk);
        chk("t1_lat1", out_valid, 0);
        @(negedge clk);
        chk("t1_lat2", out_valid, 0);
        @(negedge clk);
        chk("t1_lat3", out_valid, 1);
        tick(1);
        drain();
        chk_obs("t1_x0", n0, 16'h0800);
        chk_obs("t1_x1", n0 + 1, 16'hF800);

        // 2: both products clamp
        n0 = obs.size();
        send(17'h1FFFF, 16'h7FFF, 16'h8000);
        drain();
        chk_obs("t2_x0", n0, 16'h7FFF);
        chk_obs("t2_x1", n0 + 1, 16'h8000);
        @(negedge clk);
        chk("t2_sat", sat_count, SATCNT ? 2 : 0);
        tick(1);

        // 3: sink stalled, source always valid
        rdy_set = 1'b0;
        tick(2);
        a0 = accepts;
        n0 = obs.size();
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            f = 17'($urandom_range(0, 17'h1FFFF));
            g0 = 16'($urandom);
            g1 = 16'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        chk("t3_accepts", accepts - a0, DEPTH);
        @(negedge clk);
        chk("t3_in_ready", in_ready, 0);
        tick(1);
        rdy_set = 1'b1;
        drain();
        chk("t3_drained", obs.size() - n0, 2 * DEPTH);

        // 4: toggling sink, 20 pairs
        toggle = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(17'($urandom_range(0, 17'h1FFFF)), 16'($urandom), 16'($urandom));
        end
        drain();
        toggle = 1'b0;
        rdy_set = 1'b1;
        tick(2);

        // 5: reset with buffered data
        rdy_set = 1'b0;
        tick(1);
        send(17'h04000, 16'h1234, 16'h4321);
        send(17'h1FFFF, 16'h7FFF, 16'h7FFF);
        tick(4);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_ov", out_valid, 0);
        chk("t5_rst_sat", sat_count, 0);
        chk("t5_rst_data", out_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rdy_set = 1'b1;
        n0 = obs.size();
        send(17'h02000, 16'h2000, 16'h1000);
        drain();
        chk_obs("t5_first_x0", n0, 16'h0400);
        chk_obs("t5_first_x1", n0 + 1, 16'h0200);

        // 6: zero operands give zero, no clamps
        n0 = obs.size();
        for (int i = 0; i < 3; i++) begin
            send(17'h0, 16'($urandom), 16'($urandom));
        end
        send(17'h1FFFF, 16'h0000, 16'h0000);
        drain();
        for (int i = 0; i < 8; i++) begin
            chk_obs("t6_zero", n0 + i, 16'h0000);
        end
        @(negedge clk);
        chk("t6_sat", sat_count, 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
